// File: rtl/power_result_sink.sv
// Receive-side sink for the power block's result stream: a first-word-fall-through FIFO
// with a valid/ready output port, plus accept/drop accounting because the upstream cannot stall.
module power_result_sink #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_clear,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_full,
  output logic                    o_overflow,
  output logic [CNT_WIDTH-1:0]    o_accept_cnt,
  output logic [CNT_WIDTH-1:0]    o_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] accept_q, accept_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign full = (level_q == LVL_W'(DEPTH));
  assign pop  = (level_q != '0) && i_ready;
  assign push = i_valid && (!full || pop);
  assign drop = i_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    accept_d   = accept_q;
    drop_d     = drop_q;

    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
      accept_d   = '0;
      drop_d     = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase

      // Counters stick at all-ones rather than wrapping.
      if (push && (accept_q != '1)) begin
        accept_d = accept_q + CNT_WIDTH'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != '1) begin
          drop_d = drop_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      accept_q   <= '0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      accept_q   <= accept_d;
      drop_q     <= drop_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !i_clear) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_valid      = (level_q != '0);
  assign o_data       = mem_q[rd_ptr_q];
  assign o_level      = level_q;
  assign o_full       = full;
  assign o_overflow   = overflow_q;
  assign o_accept_cnt = accept_q;
  assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_power_result_sink.sv
// Directed bench for power_result_sink: pass-through, overflow, full push/pop,
// pointer wrap, clear priority and asynchronous reset.
module tb_power_result_sink;

  logic        clk;
  logic        reset_n;
  logic        i_valid;
  logic [63:0] i_data;
  logic        i_clear;
  logic        o_valid;
  logic [63:0] o_data;
  logic        i_ready;
  logic [3:0]  o_level;
  logic        o_full;
  logic        o_overflow;
  logic [31:0] o_accept_cnt;
  logic [31:0] o_drop_cnt;

  int total;
  int bad;

  power_result_sink dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_clear      (i_clear),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .i_ready      (i_ready),
    .o_level      (o_level),
    .o_full       (o_full),
    .o_overflow   (o_overflow),
    .o_accept_cnt (o_accept_cnt),
    .o_drop_cnt   (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doClear();
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_clear = 1'b0;
    i_ready = 1'b0;
    #12;
    total++;
    if ({o_valid, o_full, o_overflow, o_level} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %0h expected 0", {o_valid, o_full, o_overflow, o_level});
    end
    total++;
    if ({o_accept_cnt, o_drop_cnt} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL reset_counts: got %0h expected 0", {o_accept_cnt, o_drop_cnt});
    end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_pass_through();
    logic [63:0] beats [5];
    beats[0] = 64'h4;
    beats[1] = 64'h9;
    beats[2] = 64'h19;
    beats[3] = 64'h31;
    beats[4] = 64'h64;
    @(negedge clk);
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = beats[i];
      tick();
      total++;
      if (o_valid !== 1'b1 || o_data !== beats[i] || o_level !== 4'd1) begin
        bad++;
        $display("[TB] FAIL pass_beat%0d: got v=%0b d=%0h l=%0d expected v=1 d=%0h l=1",
                 i, o_valid, o_data, o_level, beats[i]);
      end
    end
    i_valid = 1'b0;
    tick();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pass_empty: got %0b expected 0", o_valid);
    end
    total++;
    if (o_accept_cnt !== 32'd5 || o_drop_cnt !== 32'd0 || o_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL pass_counts: got acc=%0d drop=%0d ovf=%0b expected acc=5 drop=0 ovf=0",
               o_accept_cnt, o_drop_cnt, o_overflow);
    end
  endtask

  task automatic test_fill_overflow();
    doClear();
    for (int k = 1; k <= 10; k++) begin
      i_valid = 1'b1;
      i_data  = 64'(k);
      tick();
      if (k == 7) begin
        total++;
        if (o_full !== 1'b0 || o_level !== 4'd7) begin
          bad++;
          $display("[TB] FAIL fill_beat7: got full=%0b l=%0d expected full=0 l=7", o_full, o_level);
        end
      end
      if (k == 8) begin
        total++;
        if (o_full !== 1'b1 || o_level !== 4'd8) begin
          bad++;
          $display("[TB] FAIL fill_beat8: got full=%0b l=%0d expected full=1 l=8", o_full, o_level);
        end
      end
    end
    i_valid = 1'b0;
    total++;
    if (o_drop_cnt !== 32'd2 || o_overflow !== 1'b1 || o_accept_cnt !== 32'd8) begin
      bad++;
      $display("[TB] FAIL fill_drops: got drop=%0d ovf=%0b acc=%0d expected drop=2 ovf=1 acc=8",
               o_drop_cnt, o_overflow, o_accept_cnt);
    end
    i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      total++;
      if (o_valid !== 1'b1 || o_data !== 64'(k)) begin
        bad++;
        $display("[TB] FAIL drain_%0d: got v=%0b d=%0h expected v=1 d=%0h", k, o_valid, o_data, k);
      end
      tick();
    end
    total++;
    if (o_valid !== 1'b0 || o_level !== 4'd0 || o_overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL drain_end: got v=%0b l=%0d ovf=%0b expected v=0 l=0 ovf=1",
               o_valid, o_level, o_overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] expq [11];
    for (int k = 0; k < 8; k++) expq[k] = 64'h100 + 64'(k);
    for (int j = 0; j < 3; j++) expq[8 + j] = 64'h200 + 64'(j);
    doClear();
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1;
      i_data  = 64'h100 + 64'(k);
      tick();
    end
    i_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      i_data = 64'h200 + 64'(j);
      total++;
      if (o_data !== expq[j]) begin
        bad++;
        $display("[TB] FAIL full_pp_head%0d: got %0h expected %0h", j, o_data, expq[j]);
      end
      tick();
      total++;
      if (o_level !== 4'd8 || o_drop_cnt !== 32'd0) begin
        bad++;
        $display("[TB] FAIL full_pp_level%0d: got l=%0d drop=%0d expected l=8 drop=0",
                 j, o_level, o_drop_cnt);
      end
    end
    i_valid = 1'b0;
    for (int j = 3; j < 11; j++) begin
      total++;
      if (o_valid !== 1'b1 || o_data !== expq[j]) begin
        bad++;
        $display("[TB] FAIL full_pp_drain%0d: got v=%0b d=%0h expected v=1 d=%0h",
                 j, o_valid, o_data, expq[j]);
      end
      tick();
    end
    total++;
    if (o_valid !== 1'b0 || o_accept_cnt !== 32'd11) begin
      bad++;
      $display("[TB] FAIL full_pp_end: got v=%0b acc=%0d expected v=0 acc=11", o_valid, o_accept_cnt);
    end
  endtask

  task automatic test_wrap();
    int rx;
    int levelErrs;
    int orderErrs;
    rx = 0;
    levelErrs = 0;
    orderErrs = 0;
    doClear();
    for (int c = 0; c < 40; c++) begin
      i_valid = (c % 2 == 0);
      i_data  = 64'h300 + 64'(c / 2);
      i_ready = ((c % 4) < 2);
      if (o_valid && i_ready) begin
        if (o_data !== 64'h300 + 64'(rx)) orderErrs++;
        rx++;
      end
      tick();
      if (o_level > 4'd8) levelErrs++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 30 && o_valid; c++) begin
      if (o_data !== 64'h300 + 64'(rx)) orderErrs++;
      rx++;
      tick();
    end
    total++;
    if (orderErrs != 0) begin
      bad++;
      $display("[TB] FAIL wrap_order: got %0d misordered beats expected 0", orderErrs);
    end
    total++;
    if (rx != 20 || levelErrs != 0) begin
      bad++;
      $display("[TB] FAIL wrap_count: got rx=%0d lvlerr=%0d expected rx=20 lvlerr=0", rx, levelErrs);
    end
    total++;
    if (o_level !== 4'd0 || o_drop_cnt !== 32'd0 || o_accept_cnt !== 32'd20) begin
      bad++;
      $display("[TB] FAIL wrap_end: got l=%0d drop=%0d acc=%0d expected l=0 drop=0 acc=20",
               o_level, o_drop_cnt, o_accept_cnt);
    end
  endtask

  task automatic test_clear_vs_push();
    doClear();
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1;
      i_data  = 64'h400 + 64'(k);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    i_ready = 1'b0;
    total++;
    if (o_level !== 4'd3 || o_overflow !== 1'b1) begin
      bad++;
      $display("[TB] FAIL clear_setup: got l=%0d ovf=%0b expected l=3 ovf=1", o_level, o_overflow);
    end
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data  = 64'hDEAD;
    tick();
    i_clear = 1'b0;
    i_valid = 1'b0;
    total++;
    if (o_level !== 4'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0 ||
        o_accept_cnt !== 32'd0 || o_drop_cnt !== 32'd0) begin
      bad++;
      $display("[TB] FAIL clear_state: got l=%0d v=%0b ovf=%0b acc=%0d drop=%0d expected all 0",
               o_level, o_valid, o_overflow, o_accept_cnt, o_drop_cnt);
    end
    tick();
    total++;
    if (o_valid !== 1'b0 || o_level !== 4'd0) begin
      bad++;
      $display("[TB] FAIL clear_nostore: got v=%0b l=%0d expected v=0 l=0", o_valid, o_level);
    end
  endtask

  task automatic test_async_reset();
    doClear();
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_data  = 64'h500 + 64'(k);
      tick();
    end
    i_valid = 1'b0;
    total++;
    if (o_level !== 4'd4) begin
      bad++;
      $display("[TB] FAIL areset_setup: got %0d expected 4", o_level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({o_valid, o_full, o_overflow, o_level} !== 7'd0 ||
        o_accept_cnt !== 32'd0 || o_drop_cnt !== 32'd0) begin
      bad++;
      $display("[TB] FAIL areset_now: got v=%0b f=%0b ovf=%0b l=%0d acc=%0d drop=%0d expected all 0",
               o_valid, o_full, o_overflow, o_level, o_accept_cnt, o_drop_cnt);
    end
    #2;
    reset_n = 1'b1;
    i_valid = 1'b1;
    i_data  = 64'hABC;
    tick();
    i_valid = 1'b0;
    total++;
    if (o_level !== 4'd1 || o_valid !== 1'b1 || o_data !== 64'hABC || o_accept_cnt !== 32'd1) begin
      bad++;
      $display("[TB] FAIL areset_push: got l=%0d v=%0b d=%0h acc=%0d expected l=1 v=1 d=abc acc=1",
               o_level, o_valid, o_data, o_accept_cnt);
    end
    i_ready = 1'b1;
    tick();
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL areset_only: got v=%0b expected 0", o_valid);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_pass_through();
    test_fill_overflow();
    test_back_to_back();
    test_wrap();
    test_clear_vs_push();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
